// File: rtl/isp_pkg.sv
// Shared definitions for the Bayer-domain ISP stages: gain format,
// CFA channel encodings and CFA phase encodings.
package isp_pkg;

    // Unsigned Q4.8 gain format
    localparam int                GAIN_W     = 12;
    localparam int                GAIN_FRAC  = 8;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 12'h100;

    // Colour channel of the current pixel
    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_GR = 2'd1,
        FMT_GB = 2'd2,
        FMT_B  = 2'd3
    } cfa_fmt_e;

    // CFA phase of the first pixel of a frame
    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_e;

    // Channel under the current pixel given the frame phase and line/pixel parity
    function automatic cfa_fmt_e cfa_fmt(bayer_e ph, logic odd_line, logic odd_pix);
        return cfa_fmt_e'(ph ^ {odd_line, odd_pix});
    endfunction

endpackage

// File: rtl/isp_wb_stat_if.sv
// Raw pixel stream in and out of the white-balance stage.
interface isp_wb_stat_if #(
    parameter int BITS = 8
);
    logic            in_href;
    logic            in_vsync;
    logic            in_de;
    logic [BITS-1:0] in_raw;
    logic            out_href;
    logic            out_vsync;
    logic            out_de;
    logic [BITS-1:0] out_raw;

    // Upstream source / downstream sink side
    modport master (
        output in_href, in_vsync, in_de, in_raw,
        input  out_href, out_vsync, out_de, out_raw
    );

    // The white-balance stage itself
    modport slave (
        input  in_href, in_vsync, in_de, in_raw,
        output out_href, out_vsync, out_de, out_raw
    );
endinterface

// File: rtl/isp_bayer_phase.sv
// Tracks line/pixel parity of the raw stream and reports the CFA channel
// of the pixel currently on the input. Shared by the Bayer-domain stages.
module isp_bayer_phase
    import isp_pkg::*;
#(
    parameter int BAYER = 0
) (
    input  logic     pclk,
    input  logic     rst,
    input  logic     in_href,
    input  logic     in_vsync,
    output cfa_fmt_e fmt
);

    localparam bayer_e PHASE = bayer_e'(2'(BAYER));

    logic odd_pix;
    logic odd_line;
    logic href_q;

    // Pixel parity follows href; line parity flips at every line end, restarts with vsync
    always_ff @(posedge pclk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            odd_pix  <= 1'b0;
            odd_line <= 1'b0;
            href_q   <= 1'b0;
        end else begin
            href_q  <= in_href;
            odd_pix <= in_href ? ~odd_pix : 1'b0;
            if (in_vsync) begin
                odd_line <= 1'b0;
            end else if (href_q && !in_href) begin
                odd_line <= ~odd_line;
            end
        end
    end

    assign fmt = cfa_fmt(PHASE, odd_line, odd_pix);

endmodule

// File: rtl/isp_wb_stat.sv
// Bayer white-balance gain with per-channel AWB statistics.
// Two-cycle gain/round/clip datapath; gains are shadowed and switch only at
// the vsync rising edge. Pre-gain sums of unsaturated pixels are published
// once per non-empty frame at the following vsync rising edge.
module isp_wb_stat
    import isp_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int BAYER  = 0,
    parameter int SUM_W  = 32
) (
    input  logic              pclk,
    input  logic              rst,
    isp_wb_stat_if.slave      pix,
    input  logic [GAIN_W-1:0] gain_r,
    input  logic [GAIN_W-1:0] gain_gr,
    input  logic [GAIN_W-1:0] gain_gb,
    input  logic [GAIN_W-1:0] gain_b,
    input  logic [BITS-1:0]   sat_thr,
    output logic [SUM_W-1:0]  stat_sum_r,
    output logic [SUM_W-1:0]  stat_sum_gr,
    output logic [SUM_W-1:0]  stat_sum_gb,
    output logic [SUM_W-1:0]  stat_sum_b,
    output logic [23:0]       stat_sat_cnt,
    output logic              stat_valid
);

    localparam int              PROD_W  = BITS + GAIN_W;
    localparam int              RND_W   = PROD_W + 1 - GAIN_FRAC;
    localparam int              CNT_W   = 24;
    localparam logic [BITS-1:0] PIX_MAX = '1;

    // Frames larger than the pixel counter range simply saturate it; only zero/non-zero matters.
    if (WIDTH * HEIGHT > (1 << CNT_W) - 1) begin : g_pix_cnt_saturates
    end

    // ------------------------------------------------------------------
    // Phase and frame-edge detection
    // ------------------------------------------------------------------
    cfa_fmt_e fmt;
    logic     vsync_q;
    logic     vs_rise;

    isp_bayer_phase #(.BAYER(BAYER)) u_phase (
        .pclk     (pclk),
        .rst      (rst),
        .in_href  (pix.in_href),
        .in_vsync (pix.in_vsync),
        .fmt      (fmt)
    );

    // Previous vsync for rising-edge detection
    always_ff @(posedge pclk) begin
        if (rst) vsync_q <= 1'b0;
        else     vsync_q <= pix.in_vsync;
    end

    assign vs_rise = pix.in_vsync && !vsync_q;

    // ------------------------------------------------------------------
    // Gain shadows
    // ------------------------------------------------------------------
    logic [GAIN_W-1:0] gain_in  [4];
    logic [GAIN_W-1:0] gain_act [4];
    logic [GAIN_W-1:0] gain_sel;

    // Collect the firmware gains in channel order; the edge pixel already sees the new set
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        gain_in[0] = gain_r;
        gain_in[1] = gain_gr;
        gain_in[2] = gain_gb;
        gain_in[3] = gain_b;
        gain_sel   = vs_rise ? gain_in[fmt] : gain_act[fmt];
    end

    // Active gains reload only at the frame edge so a frame never tears
    always_ff @(posedge pclk) begin
        if (rst) begin
            // NOTE: this array is four live registers, not a RAM, so it is reset element by element.
            for (int i = 0; i < 4; i++) gain_act[i] <= GAIN_UNITY;
        end else if (vs_rise) begin
            gain_act <= gain_in;
        end
    end

    // ------------------------------------------------------------------
    // Gain datapath: multiply, then round-to-nearest and clip
    // ------------------------------------------------------------------
    logic [PROD_W-1:0] prod;
    logic [PROD_W:0]   prod_rnd;
    logic [RND_W-1:0]  rnd;
    logic [BITS-1:0]   clip;
    logic [BITS-1:0]   raw_now;
    logic [1:0]        href_dl;
    logic [1:0]        vsync_dl;
    logic [1:0]        de_dl;

    // Round half up in Q4.8, then clamp to the pixel range
    always_comb begin
        prod_rnd = (PROD_W + 1)'(prod) + (PROD_W + 1)'(1 << (GAIN_FRAC - 1));
        rnd      = RND_W'(prod_rnd >> GAIN_FRAC);
        clip     = (rnd > RND_W'(PIX_MAX)) ? PIX_MAX : rnd[BITS-1:0];
    end

    // Two pipeline stages with the sync signals delayed alongside the data
    always_ff @(posedge pclk) begin
        if (rst) begin
            prod     <= '0;
            raw_now  <= '0;
            href_dl  <= '0;
            vsync_dl <= '0;
            de_dl    <= '0;
        end else begin
            prod     <= PROD_W'(pix.in_raw) * PROD_W'(gain_sel);
            raw_now  <= clip;
            href_dl  <= {href_dl[0], pix.in_href};
            vsync_dl <= {vsync_dl[0], pix.in_vsync};
            de_dl    <= {de_dl[0], pix.in_de};
        end
    end

    assign pix.out_href  = href_dl[1];
    assign pix.out_vsync = vsync_dl[1];
    assign pix.out_de    = de_dl[1];
    assign pix.out_raw   = href_dl[1] ? raw_now : '0;

    // ------------------------------------------------------------------
    // AWB statistics on the pre-gain pixel
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] acc     [4];
    logic [SUM_W-1:0] acc_nxt [4];
    logic [SUM_W:0]   acc_sum;
    logic [CNT_W-1:0] sat_cnt;
    logic [CNT_W-1:0] sat_nxt;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_hit;

    assign sat_hit = (pix.in_raw >= sat_thr);

    // Next accumulator values; a frame edge restarts them with the edge pixel included
    always_comb begin
        for (int i = 0; i < 4; i++) acc_nxt[i] = vs_rise ? '0 : acc[i];
        sat_nxt = vs_rise ? '0 : sat_cnt;
        cnt_nxt = vs_rise ? '0 : pix_cnt;
        acc_sum = '0;
        if (pix.in_href) begin
            if (cnt_nxt != '1) cnt_nxt = cnt_nxt + CNT_W'(1);
            if (sat_hit) begin
                if (sat_nxt != '1) sat_nxt = sat_nxt + CNT_W'(1);
            end else begin
                acc_sum      = {1'b0, acc_nxt[fmt]} + (SUM_W + 1)'(pix.in_raw);
                acc_nxt[fmt] = acc_sum[SUM_W] ? '1 : acc_sum[SUM_W-1:0];
            end
        end
    end

    // Accumulate, and publish the finished frame at the edge if it had any pixels
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            sat_cnt      <= '0;
            pix_cnt      <= '0;
            stat_sum_r   <= '0;
            stat_sum_gr  <= '0;
            stat_sum_gb  <= '0;
            stat_sum_b   <= '0;
            stat_sat_cnt <= '0;
            stat_valid   <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            sat_cnt <= sat_nxt;
            pix_cnt <= cnt_nxt;
            if (vs_rise && pix_cnt != '0) begin
                stat_sum_r   <= acc[FMT_R];
                stat_sum_gr  <= acc[FMT_GR];
                stat_sum_gb  <= acc[FMT_GB];
                stat_sum_b   <= acc[FMT_B];
                stat_sat_cnt <= sat_cnt;
                stat_valid   <= 1'b1;
            end else begin
                stat_valid   <= 1'b0;
            end
        end
    end

endmodule
